// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    localparam int unsigned NREQ_MIN = 2;
    localparam int unsigned NREQ_MAX = 8;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester-side and register-file-side signals of the write arbiter, grouped as one bus.
interface rf_write_arbiter_if #(
    parameter int unsigned N     = 2,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ  = 3
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic                    stall_i;
    logic [NREQ-1:0]         req_i;
    logic [NREQ*N-1:0]       req_addr_i;
    logic [NREQ*WIDTH-1:0]   req_data_i;
    logic [NREQ-1:0]         ack_o;
    logic                    wr_en_o;
    logic [N-1:0]            wr_addr_o;
    logic [WIDTH-1:0]        wr_data_o;
    logic [IDW-1:0]          grant_id_o;

    // Arbiter side.
    modport slave (
        input  stall_i, req_i, req_addr_i, req_data_i,
        output ack_o, wr_en_o, wr_addr_o, wr_data_o, grant_id_o
    );

    // Requester / register-file side.
    modport master (
        output stall_i, req_i, req_addr_i, req_data_i,
        input  ack_o, wr_en_o, wr_addr_o, wr_data_o, grant_id_o
    );

endinterface

// File: rtl/rf_write_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of elig_i starting at ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] elig_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  winner_o,
    output logic            found_o
);

    int unsigned    sum;
    logic [IDW-1:0] idx;

    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        sum      = 0;
        idx      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = 32'(ptr_i) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = IDW'(sum);
            if (!found_o && elig_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ requesters.
// Optional RF_ARB_ZERO_PROTECT_EN: address-0 grants are acked but never write.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ  = 3
) (
    input  logic             clk,
    input  logic             rst,
    rf_write_arbiter_if.slave bus
);

    localparam int unsigned IDW = $clog2(NREQ);

    if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_nreq_range
        $error("rf_write_arbiter: NREQ out of range");
    end

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             wr_en_q, wr_en_d;
    logic [N-1:0]     wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;

    logic [NREQ-1:0]  elig;
    logic [IDW-1:0]   winner;
    logic             found;
    logic             grant;
    logic [N-1:0]     sel_addr;
    logic [WIDTH-1:0] sel_data;

    // A requester acked this cycle still shows its old Req; mask it out.
    assign elig  = bus.req_i & ((state_q == WRITE) ? ~ack_q : {NREQ{1'b1}});
    assign grant = found && !bus.stall_i;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .elig_i   (elig),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .found_o  (found)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (winner == IDW'(i)) begin
                sel_addr = bus.req_addr_i[i*N +: N];
                sel_data = bus.req_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = IDLE;
        ptr_d      = ptr_q;
        ack_d      = '0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;

        case (state_q)
            IDLE:    state_d = grant ? WRITE : IDLE;
            WRITE:   state_d = grant ? WRITE : IDLE;
            default: state_d = IDLE;
        endcase

        if (grant) begin
            ack_d      = NREQ'(1) << winner;
            wr_addr_d  = sel_addr;
            wr_data_d  = sel_data;
            grant_id_d = winner;
            ptr_d      = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
`ifdef RF_ARB_ZERO_PROTECT_EN
            wr_en_d    = (sel_addr != '0);
`else
            wr_en_d    = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            ack_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign bus.ack_o      = ack_q;
    assign bus.wr_en_o    = wr_en_q;
    assign bus.wr_addr_o  = wr_addr_q;
    assign bus.wr_data_o  = wr_data_q;
    assign bus.grant_id_o = grant_id_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed, table-driven bench for rf_write_arbiter (default N=2, WIDTH=16, NREQ=3).
module tb_rf_write_arbiter;

    logic clk;
    logic rst;

    rf_write_arbiter_if #(.N(2), .WIDTH(16), .NREQ(3)) bus ();

    rf_write_arbiter #(.N(2), .WIDTH(16), .NREQ(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [2:0]  req;
        logic        en;
        logic [2:0]  ack;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [1:0]  gid;
    } vec_t;

    vec_t vecs [18];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic en, input logic [2:0] ack,
                                 input logic [1:0] addr, input logic [15:0] data,
                                 input logic [1:0] gid);
        check({tag, " wr_en"},    32'(bus.wr_en_o),    32'(en));
        check({tag, " ack"},      32'(bus.ack_o),      32'(ack));
        check({tag, " wr_addr"},  32'(bus.wr_addr_o),  32'(addr));
        check({tag, " wr_data"},  32'(bus.wr_data_o),  32'(data));
        check({tag, " grant_id"}, 32'(bus.grant_id_o), 32'(gid));
    endtask

    logic zp_exp_en;

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef RF_ARB_ZERO_PROTECT_EN
        zp_exp_en = 1'b0;
`else
        zp_exp_en = 1'b1;
`endif
        // Requester 0: addr 1 / 1111, requester 1: addr 3 / BEEF, requester 2: addr 2 / 2222
        //               stall req     en    ack     addr   data      gid
        vecs[0]  = '{1'b0, 3'b111, 1'b1, 3'b001, 2'd1, 16'h1111, 2'd0};
        vecs[1]  = '{1'b0, 3'b111, 1'b1, 3'b010, 2'd3, 16'hBEEF, 2'd1};
        vecs[2]  = '{1'b0, 3'b111, 1'b1, 3'b100, 2'd2, 16'h2222, 2'd2};
        vecs[3]  = '{1'b0, 3'b111, 1'b1, 3'b001, 2'd1, 16'h1111, 2'd0};
        vecs[4]  = '{1'b0, 3'b111, 1'b1, 3'b010, 2'd3, 16'hBEEF, 2'd1};
        vecs[5]  = '{1'b0, 3'b111, 1'b1, 3'b100, 2'd2, 16'h2222, 2'd2};
        vecs[6]  = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd2, 16'h2222, 2'd2};
        vecs[7]  = '{1'b0, 3'b010, 1'b1, 3'b010, 2'd3, 16'hBEEF, 2'd1};
        vecs[8]  = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd3, 16'hBEEF, 2'd1};
        vecs[9]  = '{1'b0, 3'b001, 1'b1, 3'b001, 2'd1, 16'h1111, 2'd0};
        vecs[10] = '{1'b0, 3'b001, 1'b0, 3'b000, 2'd1, 16'h1111, 2'd0};
        vecs[11] = '{1'b0, 3'b001, 1'b1, 3'b001, 2'd1, 16'h1111, 2'd0};
        vecs[12] = '{1'b0, 3'b001, 1'b0, 3'b000, 2'd1, 16'h1111, 2'd0};
        vecs[13] = '{1'b1, 3'b100, 1'b0, 3'b000, 2'd1, 16'h1111, 2'd0};
        vecs[14] = '{1'b1, 3'b100, 1'b0, 3'b000, 2'd1, 16'h1111, 2'd0};
        vecs[15] = '{1'b1, 3'b100, 1'b0, 3'b000, 2'd1, 16'h1111, 2'd0};
        vecs[16] = '{1'b0, 3'b100, 1'b1, 3'b100, 2'd2, 16'h2222, 2'd2};
        vecs[17] = '{1'b0, 3'b000, 1'b0, 3'b000, 2'd2, 16'h2222, 2'd2};

        rst            = 1'b1;
        bus.stall_i    = 1'b0;
        bus.req_i      = 3'b000;
        bus.req_addr_i = {2'd2, 2'd3, 2'd1};
        bus.req_data_i = {16'h2222, 16'hBEEF, 16'h1111};
        #12;
        check_outputs("reset", 1'b0, 3'b000, 2'd0, 16'h0000, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            bus.stall_i = vecs[i].stall;
            bus.req_i   = vecs[i].req;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].en, vecs[i].ack,
                          vecs[i].addr, vecs[i].data, vecs[i].gid);
        end

        // Address-0 request from requester 0 (ptr is 0 here): acked, write depends on macro.
        bus.req_addr_i = {2'd2, 2'd3, 2'd0};
        bus.req_data_i = {16'h2222, 16'hBEEF, 16'hA5A5};
        bus.req_i      = 3'b001;
        @(posedge clk);
        #1;
        check_outputs("zero_prot", zp_exp_en, 3'b001, 2'd0, 16'hA5A5, 2'd0);
        bus.req_i = 3'b000;
        @(posedge clk);
        #1;
        check("zero_prot idle wr_en", 32'(bus.wr_en_o), 32'(0));

        // Reset in the middle of a write; ptr was 1, so grant goes to 1 first.
        bus.req_addr_i = {2'd2, 2'd3, 2'd1};
        bus.req_data_i = {16'h2222, 16'hBEEF, 16'h1111};
        bus.req_i      = 3'b111;
        @(posedge clk);
        #1;
        check_outputs("pre_rst", 1'b1, 3'b010, 2'd3, 16'hBEEF, 2'd1);
        rst = 1'b1;
        #1;
        check_outputs("mid_rst", 1'b0, 3'b000, 2'd0, 16'h0000, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("post_rst", 1'b1, 3'b001, 2'd1, 16'h1111, 2'd0);
        bus.req_i = 3'b000;
        @(posedge clk);
        #1;
        check("post_rst drop wr_en", 32'(bus.wr_en_o), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
